// File: rtl/morse_pkg.sv
// Shared types and default letter table (A-H) for the Morse player.
// Patterns are left-aligned in 16-bit slots: bit 15 is the first unit played.
package morse_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  localparam int DEF_NUM_LETTERS = 8;
  localparam int DEF_MAX_LEN     = 16;
  localparam int DEF_LEN_W       = 5;

  // Letter i sits at slot i, so the concatenation lists H first and A last.
  localparam logic [DEF_NUM_LETTERS*DEF_MAX_LEN-1:0] DEF_PATTERNS = {
    16'hAA00,  // H 1010101
    16'hEE80,  // G 111011101
    16'hAE80,  // F 101011101
    16'h8000,  // E 1
    16'hEA00,  // D 1110101
    16'hEBA0,  // C 11101011101
    16'hEA80,  // B 111010101
    16'hB800   // A 10111
  };

  localparam logic [DEF_NUM_LETTERS*DEF_LEN_W-1:0] DEF_LENGTHS = {
    5'd7, 5'd9, 5'd9, 5'd1, 5'd7, 5'd11, 5'd9, 5'd5
  };

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/morse_player_if.sv
// Control/status bundle between the switch/key front end and the Morse player.
interface morse_player_if #(
  parameter int SEL_W = 3
) ();
  logic             start;
  logic             abort;
  logic [SEL_W-1:0] sel;
  logic             repeat_en;
  logic             out;
  logic             busy;
  logic             done;

  modport master (output start, abort, sel, repeat_en, input out, busy, done);
  modport slave  (input start, abort, sel, repeat_en, output out, busy, done);
endinterface

// File: rtl/morse_unit_timer.sv
// Free-running unit counter; tick marks the last cycle of each Morse unit.
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 25000000,
  parameter int UNIT_W      = 25
) (
  input  logic clock,
  input  logic areset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam logic [UNIT_W-1:0] LAST = UNIT_W'(UNIT_CYCLES - 1);

  logic [UNIT_W-1:0] r_cnt;

  assign tick = run && (r_cnt == LAST);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge areset) begin
    if (areset)     r_cnt <= '0;
    else if (clear) r_cnt <= '0;
    else if (run)   r_cnt <= tick ? '0 : r_cnt + UNIT_W'(1);
  end

endmodule

// File: rtl/morse_player.sv
// Plays one letter from a packed pattern table on a registered on/off output,
// with abort, busy/done status and an optional repeat mode with a forced-off gap.
module morse_player
  import morse_pkg::*;
#(
  parameter int NUM_LETTERS = 8,
  parameter int SEL_W       = 3,
  parameter int MAX_LEN     = 16,
  parameter int LEN_W       = 5,
  parameter int UNIT_CYCLES = 25000000,
  parameter int UNIT_W      = 25,
  parameter int GAP_UNITS   = 3,
  parameter logic [NUM_LETTERS*MAX_LEN-1:0] PATTERNS = DEF_PATTERNS,
  parameter logic [NUM_LETTERS*LEN_W-1:0]   LENGTHS  = DEF_LENGTHS
) (
  input logic           clock,
  input logic           areset,
  morse_player_if.slave bus
);

  localparam int GAP_W = (GAP_UNITS > 1) ? clog2(GAP_UNITS) : 1;

  state_e             r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_sel, w_lk_sel;
  logic [LEN_W-1:0]   r_idx, w_idx_nxt, w_len;
  logic [GAP_W-1:0]   r_gap, w_gap_nxt;
  logic [MAX_LEN-1:0] w_pat, w_mask;
  logic               r_out, r_busy, r_done;
  logic               w_out_nxt, w_done_nxt, w_load, w_tick;

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES),
    .UNIT_W     (UNIT_W)
  ) u_timer (
    .clock (clock),
    .areset(areset),
    .clear (bus.abort || (r_state == S_IDLE)),
    .run   (r_state != S_IDLE),
    .tick  (w_tick)
  );

  assign w_load   = (r_state == S_IDLE) && bus.start && !bus.abort;
  // Live sel only matters when idle; once playing, the latched copy drives the table.
  assign w_lk_sel = (r_state == S_IDLE) ? bus.sel : r_sel;

  always_comb begin
    w_pat = '0;
    w_len = '0;
    for (int k = 0; k < NUM_LETTERS; k++) begin
      if (w_lk_sel == SEL_W'(k)) begin
        w_pat = PATTERNS[k*MAX_LEN +: MAX_LEN];
        w_len = LENGTHS[k*LEN_W +: LEN_W];
      end
    end
    if (w_len > LEN_W'(MAX_LEN)) w_len = LEN_W'(MAX_LEN);
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_gap_nxt   = r_gap;
    w_done_nxt  = 1'b0;
    if (bus.abort) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = '0;
      w_gap_nxt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_load) begin
            w_idx_nxt = '0;
            if (w_len == '0) w_done_nxt  = 1'b1;
            else             w_state_nxt = S_PLAY;
          end
        end
        S_PLAY: begin
          if (w_tick) begin
            if (r_idx == w_len - LEN_W'(1)) begin
              w_idx_nxt = '0;
              w_gap_nxt = '0;
              if (bus.repeat_en) begin
                w_state_nxt = S_GAP;
              end else begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
              end
            end else begin
              w_idx_nxt = r_idx + LEN_W'(1);
            end
          end
        end
        S_GAP: begin
          if (w_tick) begin
            if (r_gap == GAP_W'(GAP_UNITS - 1)) begin
              w_state_nxt = S_PLAY;
              w_idx_nxt   = '0;
              w_gap_nxt   = '0;
            end else begin
              w_gap_nxt = r_gap + GAP_W'(1);
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_mask    = {1'b1, {(MAX_LEN-1){1'b0}}} >> w_idx_nxt;
  assign w_out_nxt = (w_state_nxt == S_PLAY) && |(w_pat & w_mask);

  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_gap   <= '0;
      r_sel   <= '0;
      r_out   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_gap   <= w_gap_nxt;
      if (w_load) r_sel <= bus.sel;
      r_out   <= w_out_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
    end
  end

  assign bus.out  = r_out;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_morse_player.sv
// Directed bench: default A-H table on dut_a, reduced 6-letter table with a
// zero-length and an over-long entry on dut_b; UNIT_CYCLES=4, GAP_UNITS=3.
module tb_morse_player;

  localparam int UC = 4;

  logic clk = 1'b0;
  logic areset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  morse_player_if #(.SEL_W(3)) bus_a ();
  morse_player_if #(.SEL_W(3)) bus_b ();

  morse_player #(
    .NUM_LETTERS(8), .SEL_W(3), .MAX_LEN(16), .LEN_W(5),
    .UNIT_CYCLES(UC), .UNIT_W(3), .GAP_UNITS(3)
  ) dut_a (
    .clock (clk),
    .areset(areset),
    .bus   (bus_a)
  );

  // Letter 2 has length 0, letter 5 has length 31 (clamped to 16).
  morse_player #(
    .NUM_LETTERS(6), .SEL_W(3), .MAX_LEN(16), .LEN_W(5),
    .UNIT_CYCLES(UC), .UNIT_W(3), .GAP_UNITS(3),
    .PATTERNS({16'hAE80, 16'h8000, 16'hEA00, 16'hEBA0, 16'hEA80, 16'hB800}),
    .LENGTHS ({5'd31, 5'd1, 5'd7, 5'd0, 5'd9, 5'd5})
  ) dut_b (
    .clock (clk),
    .areset(areset),
    .bus   (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int d, input logic st, input logic ab,
                        input logic [2:0] s, input logic rp);
    if (d == 0) begin
      bus_a.start = st; bus_a.abort = ab; bus_a.sel = s; bus_a.repeat_en = rp;
    end else begin
      bus_b.start = st; bus_b.abort = ab; bus_b.sel = s; bus_b.repeat_en = rp;
    end
  endtask

  task automatic check_outs(input string tag, input int d,
                            input logic e_out, input logic e_busy, input logic e_done);
    logic o, b, dn;
    o  = (d == 0) ? bus_a.out  : bus_b.out;
    b  = (d == 0) ? bus_a.busy : bus_b.busy;
    dn = (d == 0) ? bus_a.done : bus_b.done;
    check({tag, ".out"},  32'(o),  32'(e_out));
    check({tag, ".busy"}, 32'(b),  32'(e_busy));
    check({tag, ".done"}, 32'(dn), 32'(e_done));
  endtask

  // Starts a letter and checks every cycle up to the done pulse and one cycle after.
  task automatic play_letter(input int d, input string tag, input logic [2:0] s,
                             input logic [15:0] pat, input int len);
    set_in(d, 1'b1, 1'b0, s, 1'b0);
    tick();
    set_in(d, 1'b0, 1'b0, s, 1'b0);
    for (int k = 0; k < len*UC; k++) begin
      logic [15:0] pv;
      pv = pat << (k / UC);
      check_outs(tag, d, pv[15], 1'b1, 1'b0);
      tick();
    end
    check_outs({tag, "_end"}, d, 1'b0, 1'b0, 1'b1);
    tick();
    check_outs({tag, "_post"}, d, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] pv;
    areset = 1'b1;
    set_in(0, 1'b0, 1'b0, 3'd0, 1'b0);
    set_in(1, 1'b0, 1'b0, 3'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 0, 1'b0, 1'b0, 1'b0);
    check_outs("reset_b", 1, 1'b0, 1'b0, 1'b0);
    areset = 1'b0;
    tick();
    check_outs("idle", 0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of C: outputs drop without waiting for a clock edge.
    set_in(0, 1'b1, 1'b0, 3'd2, 1'b0);
    tick();
    set_in(0, 1'b0, 1'b0, 3'd2, 1'b0);
    tick();
    tick();
    check_outs("c_play", 0, 1'b1, 1'b1, 1'b0);
    #2 areset = 1'b1;
    #1 check_outs("reset_mid", 0, 1'b0, 1'b0, 1'b0);
    tick();
    areset = 1'b0;
    tick();
    check_outs("after_reset", 0, 1'b0, 1'b0, 1'b0);

    // A after reset: 1x4, 0x4, 1x12, done at N+21.
    play_letter(0, "A", 3'd0, 16'hB800, 5);

    // E with repeat: play, 12-cycle gap, play again; repeat cleared mid second play.
    set_in(0, 1'b1, 1'b0, 3'd4, 1'b1);
    tick();
    set_in(0, 1'b0, 1'b0, 3'd4, 1'b1);
    for (int k = 1; k <= 21; k++) begin
      check_outs("E_rep", 0, (k <= 4) || (k >= 17 && k <= 20), k <= 20, k == 21);
      if (k == 18) set_in(0, 1'b0, 1'b0, 3'd4, 1'b0);
      tick();
    end
    check_outs("E_rep_post", 0, 1'b0, 1'b0, 1'b0);

    // Abort with start in the 7th cycle of A.
    set_in(0, 1'b1, 1'b0, 3'd0, 1'b0);
    tick();
    set_in(0, 1'b0, 1'b0, 3'd0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      pv = 16'hB800 << ((k - 1) / UC);
      check_outs("A_pre_abort", 0, pv[15], 1'b1, 1'b0);
      if (k < 7) tick();
    end
    set_in(0, 1'b1, 1'b1, 3'd0, 1'b0);
    tick();
    check_outs("abort", 0, 1'b0, 1'b0, 1'b0);
    set_in(0, 1'b0, 1'b0, 3'd0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check_outs("abort_idle", 0, 1'b0, 1'b0, 1'b0);
    end

    // Abort beats start while idle.
    set_in(0, 1'b1, 1'b1, 3'd4, 1'b0);
    tick();
    check_outs("abort_vs_start", 0, 1'b0, 1'b0, 1'b0);
    set_in(0, 1'b0, 1'b0, 3'd4, 1'b0);
    tick();
    check_outs("abort_vs_start2", 0, 1'b0, 1'b0, 1'b0);

    // D with sel change and start pulse while busy: D plays unchanged, one done.
    set_in(0, 1'b1, 1'b0, 3'd3, 1'b0);
    tick();
    set_in(0, 1'b0, 1'b0, 3'd3, 1'b0);
    for (int k = 1; k <= 29; k++) begin
      pv = 16'hEA00 << ((k - 1) / UC);
      check_outs("D_busy", 0, (k <= 28) && pv[15], k <= 28, k == 29);
      if (k == 5) set_in(0, 1'b1, 1'b0, 3'd0, 1'b0);
      if (k == 6) set_in(0, 1'b0, 1'b0, 3'd1, 1'b0);
      tick();
    end
    check_outs("D_post", 0, 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("D_post2", 0, 1'b0, 1'b0, 1'b0);

    // Reduced table: zero-length entry and out-of-range sel give an immediate done.
    set_in(1, 1'b1, 1'b0, 3'd2, 1'b0);
    tick();
    set_in(1, 1'b0, 1'b0, 3'd2, 1'b0);
    check_outs("len0", 1, 1'b0, 1'b0, 1'b1);
    tick();
    check_outs("len0_post", 1, 1'b0, 1'b0, 1'b0);

    set_in(1, 1'b1, 1'b0, 3'd7, 1'b0);
    tick();
    set_in(1, 1'b0, 1'b0, 3'd7, 1'b0);
    check_outs("sel7", 1, 1'b0, 1'b0, 1'b1);
    tick();
    check_outs("sel7_post", 1, 1'b0, 1'b0, 1'b0);

    // Over-long length clamps to 16 units; a one-unit letter for the minimum case.
    play_letter(1, "F_clamp", 3'd5, 16'hAE80, 16);
    play_letter(1, "E_b", 3'd4, 16'h8000, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
